// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder (with full_adder cell)
// Description : Bit-serial WIDTH-bit adder. Operands are captured on a start
//               pulse, added LSB-first one bit per clock through a single
//               reused full_adder cell, and the result is presented in
//               parallel together with a one-cycle done strobe.
// Revision    : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// full_adder : single-bit combinational adder cell
// ----------------------------------------------------------------------------
module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_ci,
    output logic o_s,
    output logic o_co
);

    assign o_s  = i_a ^ i_b ^ i_ci;
    assign o_co = (i_a & i_b) | (i_ci & (i_a ^ i_b));

endmodule

// ----------------------------------------------------------------------------
// serial_adder : sequencing stage around one full_adder instance
// ----------------------------------------------------------------------------
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    // Counter only has to reach WIDTH-1, so $clog2(WIDTH) bits suffice.
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_psum;
    logic             r_cff;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;

    logic             w_fa_s;
    logic             w_fa_co;
    logic             w_accept;
    logic             w_step;
    logic             w_last;

    // The one and only adder cell; it sees the current LSBs and the carry FF.
    full_adder u_fa (
        .i_a  (r_a[0]),
        .i_b  (r_b[0]),
        .i_ci (r_cff),
        .o_s  (w_fa_s),
        .o_co (w_fa_co)
    );

    assign w_accept = (r_state == ST_IDLE) && start;
    assign w_step   = (r_state == ST_RUN);
    assign w_last   = w_step && (r_cnt == c_LAST);

    // State register; reset wins over any pending start.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: IDLE waits for start, RUN lasts WIDTH cycles, DONE is one cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start)  w_state_nxt = ST_RUN;
            ST_RUN:  if (w_last) w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Operand shift registers, carry FF, partial sum and bit counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a    <= '0;
            r_b    <= '0;
            r_psum <= '0;
            r_cff  <= 1'b0;
            r_cnt  <= '0;
        end else if (w_accept) begin
            r_a    <= a;
            r_b    <= b;
            r_psum <= '0;
            r_cff  <= cin;
            r_cnt  <= '0;
        end else if (w_step) begin
            r_a    <= r_a >> 1;
            r_b    <= r_b >> 1;
            r_psum <= {w_fa_s, r_psum[WIDTH-1:1]};
            r_cff  <= w_fa_co;
            r_cnt  <= r_cnt + 1'b1;
        end
    end

    // Result registers only move on the final bit, so partial sums never leak out.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum   <= '0;
            r_carry <= 1'b0;
        end else if (w_last) begin
            r_sum   <= {w_fa_s, r_psum[WIDTH-1:1]};
            r_carry <= w_fa_co;
        end
    end

    assign busy  = (r_state == ST_RUN);
    assign done  = (r_state == ST_DONE);
    assign sum   = r_sum;
    assign carry = r_carry;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_adder
// Description : Self-checking bench for serial_adder (WIDTH = 8): directed
//               vector table, multi-cycle corner sequences and a randomized
//               run against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry;

    int n_total = 0;
    int n_pass  = 0;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .carry (carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] va;
        logic [7:0] vb;
        logic       vc;
        logic [7:0] es;
        logic       ec;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    // One rising edge, then settle 1 time unit so outputs are sampled off the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one addition and check latency, busy length, result and hold.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_, input logic tc,
                          input logic [7:0] es, input logic ec);
        int lat;
        int bcyc;
        logic [7:0] held_s;
        a = ta; b = tb_; cin = tc; start = 1'b1;
        tick();
        start = 1'b0;
        a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
        lat = 0; bcyc = 0;
        while (!done && lat < 30) begin
            if (busy) bcyc++;
            tick();
            lat++;
        end
        check("latency", lat, WIDTH);
        check("busy_cycles", bcyc, WIDTH);
        check("busy_at_done", busy, 0);
        check("sum", sum, es);
        check("carry", carry, ec);
        held_s = sum;
        tick();
        check("done_one_cycle", done, 0);
        check("sum_held", sum, es);
    endtask

    initial begin
        int k, next_ok, exp_edge, acc_edge, accepts, dones;
        logic [8:0] exp_val;

        vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[3] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
        vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[5] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
        vecs[6] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
        vecs[7] = '{8'h01, 8'h02, 1'b0, 8'h03, 1'b0};

        // Reset with start held high: nothing may be accepted.
        rst = 1'b1; start = 1'b1; a = 8'h5A; b = 8'h3C; cin = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            check("rst_sum", sum, 0);
            check("rst_carry", carry, 0);
        end
        start = 1'b0;
        rst = 1'b0;
        tick();
        check("post_rst_busy", busy, 0);

        // Directed vector table.
        for (int i = 0; i < 8; i++)
            run_op(vecs[i].va, vecs[i].vb, vecs[i].vc, vecs[i].es, vecs[i].ec);

        // Start pulse during RUN is ignored.
        a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
        tick();                                   // E0
        start = 1'b0;
        tick(); tick(); tick();                   // E1..E3
        a = 8'hAA; b = 8'h55; start = 1'b1;
        tick();                                   // E4, ignored
        start = 1'b0;
        k = 4; dones = 0;
        while (!done && k < 30) begin tick(); k++; end
        check("ign_latency", k, WIDTH);
        check("ign_sum", sum, 8'h46);
        check("ign_carry", carry, 0);
        for (int i = 0; i < 15; i++) begin
            tick();
            if (done) dones++;
        end
        check("ign_extra_done", dones, 0);

        // Reset in the middle of RUN aborts without a done.
        a = 8'h80; b = 8'h80; cin = 1'b0; start = 1'b1;
        tick();                                   // E0
        start = 1'b0;
        tick(); tick(); tick();                   // E1..E3
        rst = 1'b1;
        tick();                                   // E4 with reset
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_sum", sum, 0);
        dones = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (done) dones++;
        end
        check("abort_no_done", dones, 0);
        run_op(8'h01, 8'h02, 1'b0, 8'h03, 1'b0);

        // Randomized run: start held for the first stretch, random afterwards.
        // Model: an accept can happen only WIDTH+2 edges after the previous one;
        // its result {carry,sum} = a+b+cin shows up WIDTH edges later.
        k = 0; next_ok = 0; exp_edge = -1; acc_edge = -100; accepts = 0; exp_val = '0;
        while ((accepts < 200 || k <= exp_edge) && k < 10000) begin
            start = (accepts < 200) ? ((k < 40) ? 1'b1 : ($urandom_range(0, 3) != 0)) : 1'b0;
            a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
            if (start && k >= next_ok) begin
                exp_val  = {1'b0, a} + {1'b0, b} + {8'd0, cin};
                acc_edge = k;
                exp_edge = k + WIDTH;
                next_ok  = k + WIDTH + 2;
                accepts++;
            end
            tick();
            check("rnd_busy", busy, (k >= acc_edge && k < acc_edge + WIDTH) ? 1 : 0);
            check("rnd_done", done, (k == exp_edge) ? 1 : 0);
            if (k == exp_edge) check("rnd_result", {carry, sum}, exp_val);
            k++;
        end
        if (k >= 10000) check("rnd_timeout", k, 0);
        start = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_adder.md
# serial_adder

Bit-serial multi-bit adder built around the team's single-bit `full_adder` cell, which is instantiated once and reused every cycle. A carry flip-flop closes the loop. Operands are loaded in parallel on a start pulse and added LSB-first, one bit per clock. The result is presented in parallel with a one-cycle `done` strobe. It sits directly downstream of the `full_adder` cell as its sequencing stage, serving as the area-minimal adder for slow datapaths.

## Interface
- `WIDTH`, default 8: operand/result width in bits; legal range WIDTH ≥ 2.
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request to begin an addition; sampled only in IDLE.
- `a` input WIDTH: operand A, captured on the accepting edge.
- `b` input WIDTH: operand B, captured on the accepting edge.
- `cin` input 1: carry-in, captured on the accepting edge.
- `busy` output 1: high while bits are being processed (RUN state).
- `done` output 1: one-cycle strobe; `sum`/`carry` are valid from this cycle on.
- `sum` output WIDTH: registered result, low WIDTH bits of a+b+cin.
- `carry` output 1: registered carry-out, bit WIDTH of a+b+cin.

## Operation
- States: IDLE, RUN, DONE.
  - IDLE → RUN when `start`=1.
  - RUN → DONE after WIDTH bit-cycles.
  - DONE → IDLE unconditionally.
- Accept (IDLE, `start`=1) loads the following, then clears bit counter (width $clog2(WIDTH)):
  - shift register A←`a`
  - shift register B←`b`
  - carry FF←`cin`
  - partial-sum shift register←0
- Each RUN cycle:
  - `full_adder` inputs are A[0], B[0], carry FF.
  - The cell's sum bit shifts into the partial-sum MSB; partial-sum register shifts right.
  - A and B shift right.
  - Carry FF ← cell carry.
  - Counter increments.
- On the last RUN cycle (counter = WIDTH-1):
  - `sum` ← final partial-sum value.
  - `carry` ← final cell carry.
  - Go to DONE.
- Arithmetic: {`carry`,`sum`} = `a` + `b` + `cin`, exact, WIDTH+1 bits, no truncation.
- `sum`/`carry` change only at completion and hold until the next completion or reset. Partial results are never visible on the outputs.
- `start` is ignored in RUN and DONE. Operand inputs are ignored except on the accepting edge.
- Reset, in any state including mid-RUN:
  - returns to IDLE;
  - clears shift registers, carry FF and counter;
  - `busy`=0, `done`=0, `sum`=0, `carry`=0;
  - no `done` is produced for an aborted operation.
- `rst` has priority over `start` on the same edge.

## Timing
- E0 = edge at which `start` is accepted.
- `busy` = 1 from after E0 through the edge E_WIDTH.
- Bit i (0..WIDTH-1) is processed on edge E(i+1).
- At E_WIDTH, `sum`/`carry` are updated and state becomes DONE.
- `done` = 1 for exactly the cycle between E_WIDTH and E_(WIDTH+1). `busy` = 0 in that cycle.
- Latency, start-accept to `done`: WIDTH clocks.
- Throughput: the earliest next accept is E_(WIDTH+2), so one addition per WIDTH+2 clocks. With `start` held high, accepts recur every WIDTH+2 edges.
- Outputs are purely registered; there are no combinational paths from inputs to outputs.

## Test plan
- **Reset:** assert `rst` for 2 cycles with `start`=1 → `busy`=0, `done`=0, `sum`=0x00, `carry`=0 throughout. No accept occurs while `rst`=1.
- **Basic add (WIDTH=8):** `a`=0x5A, `b`=0x3C, `cin`=0, `start` pulse → `busy` high 8 cycles, then `done` high for 1 cycle with `sum`=0x96, `carry`=0. Values are held afterwards.
- **Carry propagation:**
  - `a`=0xFF, `b`=0x01, `cin`=0 → `sum`=0x00, `carry`=1.
  - `a`=0xFF, `b`=0xFF, `cin`=1 → `sum`=0xFF, `carry`=1.
  - `a`=0x00, `b`=0x00, `cin`=1 → `sum`=0x01, `carry`=0.
- **Start ignored while busy:** start `a`=0x12, `b`=0x34. Three cycles later pulse `start` with `a`=0xAA, `b`=0x55 → a single `done`, at the original time, with `sum`=0x46, `carry`=0.
- **Reset mid-operation:** start `a`=0x80, `b`=0x80. Assert `rst` on edge E4 → next cycle `busy`=0; no `done` ever appears. A following start with `a`=0x01, `b`=0x02 yields `sum`=0x03, `carry`=0 with normal latency.
- **Back-to-back:** hold `start`=1 with operands changing every cycle → accepts at E0, E10, E20 (WIDTH=8). Each `done` result equals the operands present at its own accepting edge. A self-checking bench compares against a+b+cin for 200 random vectors.
